// File: rtl/kernel_mem_rpt.sv
// kernel_mem_rpt: circular kernel/bias word store for the convolution datapath.
//
// The write side fills the memory sequentially from the configuration stream.
// The read side plays back one section: a bias word at rd_cfg_start, then the
// kernel words start+1 .. rd_cfg_end. Addresses wrap MEM_DEPTH-1 -> 0, and the
// kernel words are replayed rd_cfg_repeat extra times.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   wr_cfg_end/_set       last write address; the set pulse restarts the write pointer at 0
//   wr_data/_val/_rdy     write word stream (valid/ready)
//   rd_cfg_start/_end     bias address / last kernel address (inclusive)
//   rd_cfg_repeat         extra kernel passes (0 = single pass)
//   rd_cfg_set            start (or restart) a read section
//   rd_bias               bias word of the current section, held until the next one
//   rd_data/_val/_rdy     kernel word stream (valid/ready)
//   rd_busy               section in progress
//   rd_data_last          (only with KERNEL_MEM_RPT_LAST_EN) final beat of the final pass
//
// Build option: define KERNEL_MEM_RPT_LAST_EN to add rd_data_last.
//
// Timing, counted in clock edges from the edge that samples rd_cfg_set:
//   edge 1 returns the bias word from the memory,
//   edge 2 captures rd_bias and returns the first kernel word,
//   edge 3 raises rd_data_val for the first time.
module kernel_mem_rpt #(
    parameter int GROUP_NB   = 4,
    parameter int KER_WIDTH  = 16,
    parameter int DEPTH_NB   = 1,
    parameter int MEM_AWIDTH = 8,
    parameter int MEM_DEPTH  = 8,
    parameter int RPT_WIDTH  = 8,
    localparam int W = GROUP_NB * KER_WIDTH * DEPTH_NB
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [MEM_AWIDTH-1:0] wr_cfg_end,
    input  logic                  wr_cfg_set,
    input  logic [W-1:0]          wr_data,
    input  logic                  wr_data_val,
    output logic                  wr_data_rdy,
    input  logic [MEM_AWIDTH-1:0] rd_cfg_start,
    input  logic [MEM_AWIDTH-1:0] rd_cfg_end,
    input  logic [RPT_WIDTH-1:0]  rd_cfg_repeat,
    input  logic                  rd_cfg_set,
    output logic [W-1:0]          rd_bias,
    output logic [W-1:0]          rd_data,
    output logic                  rd_data_val,
    input  logic                  rd_data_rdy,
    output logic                  rd_busy
`ifdef KERNEL_MEM_RPT_LAST_EN
    ,
    output logic                  rd_data_last
`endif
);

    localparam int IDXW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [MEM_AWIDTH-1:0] LAST_A = MEM_AWIDTH'(MEM_DEPTH - 1);
    localparam logic [MEM_AWIDTH-1:0] ONE_A  = MEM_AWIDTH'(1);
    localparam logic [RPT_WIDTH-1:0]  ONE_R  = RPT_WIDTH'(1);

    function automatic logic [MEM_AWIDTH-1:0] nxt(input logic [MEM_AWIDTH-1:0] a);
        return (a == LAST_A) ? '0 : a + ONE_A;
    endfunction

    // ---------------- write path ----------------
    logic [MEM_AWIDTH-1:0] wr_ptr, wr_end;
    logic                  wr_acc;

    // A restart pulse wins over a word presented in the same cycle.
    assign wr_acc = wr_data_val & wr_data_rdy & ~wr_cfg_set;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            wr_end      <= '0;
            wr_data_rdy <= 1'b0;
        end else if (wr_cfg_set) begin
            wr_end      <= wr_cfg_end;
            wr_ptr      <= '0;
            wr_data_rdy <= 1'b1;
        end else if (wr_acc) begin
            wr_ptr <= nxt(wr_ptr);
            if (wr_ptr == wr_end) wr_data_rdy <= 1'b0;
        end
    end

    // ---------------- memory (not reset, read-first) ----------------
    logic [W-1:0]      mem [MEM_DEPTH];
    logic [W-1:0]      rd_q;
    logic              mem_en;
    logic [IDXW-1:0]   mem_idx;

    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr[IDXW-1:0]] <= wr_data;
        if (mem_en) rd_q <= mem[mem_idx];
    end

    // ---------------- read FSM ----------------
    // BIAS: bias address on the memory port.
    // LOAD: bias word on rd_q; first kernel read issued.
    // RUN : kernel reads issued against free buffer space.
    typedef enum logic [1:0] {IDLE, BIAS, LOAD, RUN} state_t;
    state_t state, state_nx;

    logic [MEM_AWIDTH-1:0] start_q, end_q, k;
    logic [RPT_WIDTH-1:0]  rep_q, pass;
    logic                  issue_done, inflight, pf_val;
    logic [W-1:0]          pf_data;
    logic                  degen, issue, credit, pop, load_out, done;
    logic [1:0]            occ;

    assign degen    = (start_q == end_q);
    assign pop      = rd_data_val & rd_data_rdy;
    assign load_out = ~rd_data_val | rd_data_rdy;
    // Words held or in flight after this cycle's pop. A new read may be issued
    // only if its data will find a free slot (output register or prefetch).
    assign occ      = {1'b0, rd_data_val} + {1'b0, pf_val} + {1'b0, inflight} - {1'b0, pop};
    assign credit   = (occ <= 2'd1);
    assign done     = issue_done & ~inflight & ~pf_val & load_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (rd_cfg_set) begin
            state_nx = BIAS;
        end else begin
            case (state)
                BIAS:    state_nx = LOAD;
                LOAD:    state_nx = degen ? IDLE : RUN;
                RUN:     if (done) state_nx = IDLE;
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_busy = (state != IDLE);
        issue   = 1'b0;
        mem_en  = 1'b0;
        mem_idx = k[IDXW-1:0];
        case (state)
            BIAS: begin
                mem_en  = 1'b1;
                mem_idx = start_q[IDXW-1:0];
            end
            LOAD:    issue = ~degen;
            RUN:     issue = ~issue_done & credit;
            default: ;
        endcase
        if (issue) mem_en = 1'b1;
    end

    // Issue-side address walk: k..end, then back to start+1 for each extra pass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q    <= '0;
            end_q      <= '0;
            rep_q      <= '0;
            k          <= '0;
            pass       <= '0;
            issue_done <= 1'b0;
        end else if (rd_cfg_set) begin
            start_q    <= rd_cfg_start;
            end_q      <= rd_cfg_end;
            rep_q      <= rd_cfg_repeat;
            k          <= nxt(rd_cfg_start);
            pass       <= '0;
            issue_done <= 1'b0;
        end else if (issue) begin
            if (k == end_q) begin
                if (pass < rep_q) begin
                    k    <= nxt(start_q);
                    pass <= pass + ONE_R;
                end else begin
                    issue_done <= 1'b1;
                end
            end else begin
                k <= nxt(k);
            end
        end
    end

    // Output register plus one prefetch entry; an abort flushes both.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_bias     <= '0;
            rd_data     <= '0;
            rd_data_val <= 1'b0;
            pf_data     <= '0;
            pf_val      <= 1'b0;
            inflight    <= 1'b0;
        end else begin
            if (state == LOAD && !rd_cfg_set) rd_bias <= rd_q;
            if (rd_cfg_set) begin
                inflight    <= 1'b0;
                pf_val      <= 1'b0;
                rd_data_val <= 1'b0;
            end else begin
                inflight <= issue;
                if (load_out) begin
                    if (pf_val) begin
                        rd_data     <= pf_data;
                        rd_data_val <= 1'b1;
                        pf_data     <= rd_q;
                        pf_val      <= inflight;
                    end else if (inflight) begin
                        rd_data     <= rd_q;
                        rd_data_val <= 1'b1;
                    end else begin
                        rd_data_val <= 1'b0;
                    end
                end else if (inflight) begin
                    pf_data <= rd_q;
                    pf_val  <= 1'b1;
                end
            end
        end
    end

`ifdef KERNEL_MEM_RPT_LAST_EN
    // The last flag travels alongside its word through the same slots.
    logic inflight_last, pf_last, issue_last;

    assign issue_last = issue & (k == end_q) & (pass == rep_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_last <= 1'b0;
            pf_last       <= 1'b0;
            rd_data_last  <= 1'b0;
        end else if (rd_cfg_set) begin
            inflight_last <= 1'b0;
            pf_last       <= 1'b0;
            rd_data_last  <= 1'b0;
        end else begin
            inflight_last <= issue_last;
            if (load_out) begin
                if (pf_val) begin
                    rd_data_last <= pf_last;
                    pf_last      <= inflight_last;
                end else if (inflight) begin
                    rd_data_last <= inflight_last;
                end else begin
                    rd_data_last <= 1'b0;
                end
            end else if (inflight) begin
                pf_last <= inflight_last;
            end
        end
    end
`endif

endmodule

// File: tb/tb_kernel_mem_rpt.sv
// Directed bench for kernel_mem_rpt: table of read sections plus hand-written
// fill, abort and reset sequences. Edge numbering inside run_section: E0 is
// the edge that samples rd_cfg_set; sample e is the negedge after E(e-1).
module tb_kernel_mem_rpt;

    localparam int W = 64;
    localparam logic [63:0] HI = 64'hDEAD_BEEF_0000_0000;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [7:0]   wr_cfg_end = '0;
    logic         wr_cfg_set = 1'b0;
    logic [W-1:0] wr_data = '0;
    logic         wr_data_val = 1'b0;
    logic         wr_data_rdy;
    logic [7:0]   rd_cfg_start = '0;
    logic [7:0]   rd_cfg_end = '0;
    logic [7:0]   rd_cfg_repeat = '0;
    logic         rd_cfg_set = 1'b0;
    logic [W-1:0] rd_bias;
    logic [W-1:0] rd_data;
    logic         rd_data_val;
    logic         rd_data_rdy = 1'b0;
    logic         rd_busy;
`ifdef KERNEL_MEM_RPT_LAST_EN
    logic         rd_data_last;
`endif

    kernel_mem_rpt dut (
        .clk(clk), .rst_n(rst_n),
        .wr_cfg_end(wr_cfg_end), .wr_cfg_set(wr_cfg_set),
        .wr_data(wr_data), .wr_data_val(wr_data_val), .wr_data_rdy(wr_data_rdy),
        .rd_cfg_start(rd_cfg_start), .rd_cfg_end(rd_cfg_end),
        .rd_cfg_repeat(rd_cfg_repeat), .rd_cfg_set(rd_cfg_set),
        .rd_bias(rd_bias), .rd_data(rd_data), .rd_data_val(rd_data_val),
        .rd_data_rdy(rd_data_rdy), .rd_busy(rd_busy)
`ifdef KERNEL_MEM_RPT_LAST_EN
        , .rd_data_last(rd_data_last)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    typedef struct {
        logic [7:0]        start;
        logic [7:0]        fin;
        logic [7:0]        rep;
        bit                tog;   // toggle rd_data_rdy every cycle
        logic [63:0]       bias;
        int                n;     // expected kernel beats
        int                fall;  // sample index where rd_busy is first 0 (0 = not checked)
        logic [7:0][63:0]  exp;
    } sec_t;

    function automatic sec_t mk(input int st, input int fi, input int rp, input bit tg,
                                input logic [63:0] b, input int n, input int fall,
                                input logic [63:0] v0, input logic [63:0] v1,
                                input logic [63:0] v2, input logic [63:0] v3,
                                input logic [63:0] v4, input logic [63:0] v5,
                                input logic [63:0] v6, input logic [63:0] v7);
        sec_t r;
        r.start = 8'(st);
        r.fin   = 8'(fi);
        r.rep   = 8'(rp);
        r.tog   = tg;
        r.bias  = b;
        r.n     = n;
        r.fall  = fall;
        r.exp   = {v7, v6, v5, v4, v3, v2, v1, v0};
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Write words hi+1 .. hi+nwords with val held; expect `acc_exp` accepted.
    task automatic fill(input logic [7:0] fend, input int nwords, input logic [63:0] hi,
                        input int acc_exp);
        int acc;
        @(posedge clk); #1;
        wr_cfg_end = fend;
        wr_cfg_set = 1'b1;
        @(posedge clk); #1;
        wr_cfg_set = 1'b0;
        @(negedge clk);
        check("wr_rdy_rise", {63'd0, wr_data_rdy}, 64'd1);
        acc = 0;
        for (int i = 1; i <= nwords; i++) begin
            @(posedge clk); #1;
            wr_data     = hi + 64'(i);
            wr_data_val = 1'b1;
            @(negedge clk);
            if (wr_data_rdy) acc++;
        end
        @(posedge clk); #1;
        wr_data_val = 1'b0;
        @(negedge clk);
        check("wr_rdy_fall", {63'd0, wr_data_rdy}, 64'd0);
        check("wr_accepted", 64'(acc), 64'(acc_exp));
    endtask

    task automatic start_sec(input logic [7:0] st, input logic [7:0] fi);
        @(posedge clk); #1;
        rd_cfg_start  = st;
        rd_cfg_end    = fi;
        rd_cfg_repeat = 8'd0;
        rd_cfg_set    = 1'b1;
        rd_data_rdy   = 1'b1;
        @(posedge clk); #1;
        rd_cfg_set = 1'b0;
    endtask

    task automatic run_section(input string tag, input sec_t s);
        int beats, first_e, fall_e;
        bit hold;
        logic [63:0] hold_d;
        @(posedge clk); #1;
        rd_cfg_start  = s.start;
        rd_cfg_end    = s.fin;
        rd_cfg_repeat = s.rep;
        rd_cfg_set    = 1'b1;
        rd_data_rdy   = 1'b1;
        @(posedge clk); #1;
        rd_cfg_set = 1'b0;
        if (s.tog) rd_data_rdy = 1'b0;
        beats = 0; first_e = -1; fall_e = -1; hold = 1'b0; hold_d = '0;
        for (int e = 1; e <= 64; e++) begin
            @(negedge clk);
            if (e == 1) begin
                check({tag, "_val_drop"}, {63'd0, rd_data_val}, 64'd0);
                check({tag, "_busy_rise"}, {63'd0, rd_busy}, 64'd1);
            end
            if (e == 3) check({tag, "_bias"}, rd_bias, s.bias);
            if (hold) begin
                check({tag, "_hold_data"}, rd_data, hold_d);
                check({tag, "_hold_val"}, {63'd0, rd_data_val}, 64'd1);
            end
            hold   = rd_data_val && !rd_data_rdy;
            hold_d = rd_data;
            if (rd_data_val && first_e < 0) first_e = e;
            if (rd_data_val && rd_data_rdy) begin
                if (beats < s.n) check($sformatf("%s_beat%0d", tag, beats), rd_data, s.exp[beats]);
`ifdef KERNEL_MEM_RPT_LAST_EN
                check($sformatf("%s_last%0d", tag, beats), {63'd0, rd_data_last},
                      {63'd0, beats == s.n - 1});
`endif
                beats++;
            end
            if (!rd_busy) begin
                fall_e = e;
                break;
            end
            @(posedge clk); #1;
            if (s.tog) rd_data_rdy = ~rd_data_rdy;
        end
        check({tag, "_beats"}, 64'(beats), 64'(s.n));
        check({tag, "_busy_fell"}, {63'd0, rd_busy}, 64'd0);
        check({tag, "_val_end"}, {63'd0, rd_data_val}, 64'd0);
        if (s.n > 0) check({tag, "_first_val"}, 64'(first_e), 64'd4);
        if (s.fall > 0) check({tag, "_busy_len"}, 64'(fall_e), 64'(s.fall));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog");
    end

    initial begin
        sec_t tbl [6];
        // memory after the first fill: mem[a] = a+1
        tbl[0] = mk(0, 4, 0, 0, 1, 4, 8,  2, 3, 4, 5, 0, 0, 0, 0);
        tbl[1] = mk(5, 1, 1, 0, 6, 8, 12, 7, 8, 1, 2, 7, 8, 1, 2);
        tbl[2] = mk(0, 4, 0, 1, 1, 4, 0,  2, 3, 4, 5, 0, 0, 0, 0);
        tbl[3] = mk(3, 3, 0, 0, 4, 0, 3,  0, 0, 0, 0, 0, 0, 0, 0);
        tbl[4] = mk(2, 1, 0, 0, 3, 7, 11, 4, 5, 6, 7, 8, 1, 2, 0);
        tbl[5] = mk(6, 7, 2, 0, 7, 3, 7,  8, 8, 8, 0, 0, 0, 0, 0);

        // reset state
        #7;
        check("rst_wr_rdy", {63'd0, wr_data_rdy}, 64'd0);
        check("rst_bias", rd_bias, 64'd0);
        check("rst_data", rd_data, 64'd0);
        check("rst_val", {63'd0, rd_data_val}, 64'd0);
        check("rst_busy", {63'd0, rd_busy}, 64'd0);
        #5 rst_n = 1'b1;

        fill(8'd7, 10, 64'd0, 8);

        for (int i = 0; i < 6; i++) run_section($sformatf("sec%0d", i), tbl[i]);

        // abort a running section with a new configuration
        start_sec(8'd0, 8'd4);
        repeat (4) @(posedge clk);
        run_section("abort", mk(0, 2, 0, 0, 1, 2, 6, 2, 3, 0, 0, 0, 0, 0, 0));

        // asynchronous reset in the middle of streaming
        start_sec(8'd0, 8'd4);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_wr_rdy", {63'd0, wr_data_rdy}, 64'd0);
        check("mid_rst_bias", rd_bias, 64'd0);
        check("mid_rst_data", rd_data, 64'd0);
        check("mid_rst_val", {63'd0, rd_data_val}, 64'd0);
        check("mid_rst_busy", {63'd0, rd_busy}, 64'd0);
`ifdef KERNEL_MEM_RPT_LAST_EN
        check("mid_rst_last", {63'd0, rd_data_last}, 64'd0);
`endif
        @(posedge clk); #3;
        rst_n = 1'b1;
        rd_data_rdy = 1'b1;

        // partial refill of words 0..1; words 2.. keep their old contents
        fill(8'd1, 3, HI, 2);
        run_section("post_rst", mk(0, 3, 0, 0, HI + 64'd1, 3, 7,
                                   HI + 64'd2, 3, 4, 0, 0, 0, 0, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/kernel_mem_rpt.md
Name: kernel_mem_rpt

Overview:
Next-generation kernel/bias store for the convolution datapath. It holds a circular memory of packed kernel words, written sequentially from the configuration stream and read back as a configurable circular section.
- Each read section: one bias word, then the kernel words.
- The kernel words can be replayed N times without reloading, serving multi-pass tiling.
- Adds a valid/ready read handshake and a busy status that the earlier generation lacks.

Parameters:
GROUP_NB, 4, kernel groups per word
KER_WIDTH, 16, bits per kernel element
DEPTH_NB, 1, elements per group per word
MEM_AWIDTH, 8, address width
MEM_DEPTH, 8, number of words; must be ≤ 2^MEM_AWIDTH
RPT_WIDTH, 8, repeat counter width
(W = GROUP_NB*KER_WIDTH*DEPTH_NB)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
wr_cfg_end  in  MEM_AWIDTH  last write address (inclusive)
wr_cfg_set  in  1  latch wr_cfg_end; write pointer := 0
wr_data  in  W  write word
wr_data_val  in  1  write valid
wr_data_rdy  out  1  write ready
rd_cfg_start  in  MEM_AWIDTH  bias address
rd_cfg_end  in  MEM_AWIDTH  last kernel address (inclusive)
rd_cfg_repeat  in  RPT_WIDTH  extra kernel passes (0 = one pass)
rd_cfg_set  in  1  start read section
rd_bias  out  W  bias word, held until next section
rd_data  out  W  kernel word
rd_data_val  out  1  rd_data valid
rd_data_rdy  in  1  consumer ready
rd_busy  out  1  section in progress

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: wr_data_rdy=0, rd_bias=0, rd_data=0, rd_data_val=0, rd_busy=0.
  - Internal: write pointer 0, write end 0, read FSM IDLE.
  - Memory contents are not cleared.
  - Reset during a read abandons the section.
- Write path:
  - wr_cfg_set latches the end address and sets ptr=0; wr_data_rdy=1 from the next cycle.
  - A word is accepted when val&rdy: mem[ptr]<=wr_data, ptr increments.
  - After the word at ptr==end is accepted, wr_data_rdy=0 until the next wr_cfg_set; further val is ignored.
  - wr_cfg_set mid-stream restarts at 0.
- Address increment: next = (a==MEM_DEPTH-1) ? 0 : a+1, for both read and write.
- Memory is synchronous read, 1-cycle latency, read-first. A read of an address written in the same cycle returns the old word.
- Read FSM states: IDLE, BIAS, LOAD, RUN.
  - IDLE: on rd_cfg_set, latch start/end/repeat, rd_busy=1, issue read at start, go to BIAS.
  - BIAS: next cycle captures rd_bias.
    - If start==end: no kernel words; return to IDLE with rd_busy=0.
    - Otherwise: k=start+1 (wrapped), issue read, go to LOAD.
  - LOAD/RUN: a one-entry output register plus one prefetch entry, so rd_data_rdy held high gives one beat per cycle with no bubbles.
    - rd_data/rd_data_val only change when !rd_data_val or rd_data_rdy.
    - The data beat sequence is k..end, wrapping MEM_DEPTH-1→0.
    - At end, if the pass counter < repeat, restart at start+1 and increment the counter. The bias is not re-read.
  - After the final beat handshakes, rd_data_val=0, rd_busy=0, and the FSM goes to IDLE.
- Kernel beats per section = ((end-start) mod MEM_DEPTH) × (repeat+1).
- rd_cfg_set while busy:
  - aborts the section and drops rd_data_val the next cycle;
  - restarts at BIAS with the new config.
- rd_data_rdy while !rd_data_val is ignored.
- Latency from rd_cfg_set to rd_bias valid: 2 cycles. First rd_data_val: 3 cycles.
- Reads and writes are independent. The caller is responsible for ordering overlapping address ranges.

Optional Feature:
KERNEL_MEM_RPT_LAST_EN
- Defined: adds output port rd_data_last (1 bit). It is 1 with the final beat of the final pass and 0 otherwise; it resets to 0.
- Undefined: the port is absent and there is no extra logic. rd_busy falling is the only end indication.

Test Plan:
- Fill: wr_cfg_end=7, wr_cfg_set, stream 10 words 1..10 with val held → words 1..8 accepted into addresses 0..7; wr_data_rdy falls after the 8th; words 9 and 10 are ignored.
- Section: start=0, end=4, repeat=0, rd_data_rdy=1 → rd_bias=1; rd_data 2,3,4,5 on consecutive cycles; rd_busy falls after beat 4.
- Wrap + repeat: start=5, end=1, repeat=1 → rd_bias=6; data 7,8,1,2,7,8,1,2; rd_data_last (if enabled) only on the final 2.
- Backpressure: same as section 0..4 with rd_data_rdy toggling 1,0,1,0 → each word is held stable while rdy=0; no loss or duplication; still exactly 4 beats.
- Degenerate/abort: start=end=3 → rd_bias=4, no data beats, busy lasts 2 cycles. Then rd_cfg_set mid-section (start=0, end=2) → old beats stop and the new sequence bias=1, data 2,3 follows.
- Reset: rst_n=0 during RUN → all outputs go to 0 immediately (async). After release, a new fill and read behave normally and memory contents are retained.
